// File: rtl/sram_bus_arbiter.sv
// Two-master sram-like arbiter: fixed priority (data over inst) on the address phase,
// in-order ID FIFO routes each data-phase response back to the master that issued it.
module sram_bus_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);
  localparam logic IdInst = 1'b0;
  localparam logic IdData = 1'b1;

  logic          lock_valid_q, lock_id_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          id_fifo_q [DEPTH];

  logic have_grant, grant, grant_req, sel_inst, can_issue, accept, resp, head_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    have_grant = lock_valid_q | data_req | inst_req;
    grant      = lock_valid_q ? lock_id_q : (data_req ? IdData : IdInst);
    grant_req  = (grant == IdData) ? data_req : inst_req;
    sel_inst   = have_grant && (grant == IdInst);
    // A response in the same cycle frees a slot, so a full FIFO may still accept.
    can_issue  = (count_q < DepthC) || mem_data_ok;
    mem_req    = !reset && have_grant && grant_req && can_issue;
    accept     = mem_req && mem_addr_ok;

    mem_addr   = sel_inst ? inst_addr : data_addr;
    mem_size   = sel_inst ? inst_size : data_size;
    mem_wr     = sel_inst ? 1'b0      : data_wr;
    mem_wstrb  = sel_inst ? 4'h0      : data_wstrb;
    mem_wdata  = sel_inst ? 32'h0     : data_wdata;

    inst_addr_ok = accept && sel_inst;
    data_addr_ok = accept && !sel_inst;

    // Responses with nothing outstanding are stale (e.g. issued before a reset).
    resp         = !reset && mem_data_ok && (count_q != '0);
    head_id      = id_fifo_q[rd_ptr_q];
    inst_data_ok = resp && (head_id == IdInst);
    data_data_ok = resp && (head_id == IdData);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      if (mem_req && !mem_addr_ok) begin
        lock_valid_q <= 1'b1;
        lock_id_q    <= grant;
      end else if (accept) begin
        lock_valid_q <= 1'b0;
      end
      if (accept) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (resp)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({accept, resp})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) id_fifo_q[wr_ptr_q] <= grant;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed per-cycle vector table plus a randomized
// alternating-master run checked against an in-order ownership scoreboard.
module tb_sram_bus_arbiter;

  localparam logic [31:0] IA = 32'h1C000000;
  localparam logic [31:0] DA = 32'h1C008000;
  localparam logic [31:0] WD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic [1:0]  inst_size;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  sram_bus_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, ireq, dreq, dwr, aok, dok;
    logic [31:0] rdata;
    logic        e_req, e_iao, e_dao, e_ido, e_ddo, e_sel;  // e_sel: 1 = M1 drives address phase
  } vec_t;

  function automatic vec_t mk(input logic [5:0] in, input logic [31:0] rd, input logic [5:0] ex);
    vec_t v;
    {v.rst, v.ireq, v.dreq, v.dwr, v.aok, v.dok}       = in;
    v.rdata                                            = rd;
    {v.e_req, v.e_iao, v.e_dao, v.e_ido, v.e_ddo, v.e_sel} = ex;
    return v;
  endfunction

  vec_t vecs[25];
  vec_t exp_q[$];
  logic pend_q[$];
  int   issued;

  initial begin
    // in: rst ireq dreq dwr aok dok    exp: req iao dao ido ddo sel
    vecs[0]  = mk(6'b111011, 32'h0,        6'b000001); // reset forces handshakes low
    vecs[1]  = mk(6'b010010, 32'h0,        6'b110000); // inst fetch accepted
    vecs[2]  = mk(6'b000010, 32'h0,        6'b000001); // idle: mux defaults to M1
    vecs[3]  = mk(6'b000011, 32'h02800c0c, 6'b000101); // inst response
    vecs[4]  = mk(6'b011110, 32'h0,        6'b101001); // both req: data write wins
    vecs[5]  = mk(6'b010010, 32'h0,        6'b110000); // inst follows
    vecs[6]  = mk(6'b000011, 32'h11111111, 6'b000011); // in order: data first
    vecs[7]  = mk(6'b000011, 32'h22222222, 6'b000101); // then inst
    vecs[8]  = mk(6'b010000, 32'h0,        6'b100000); // inst stalled -> lock
    vecs[9]  = mk(6'b011000, 32'h0,        6'b100000); // data rises, inst keeps grant
    vecs[10] = mk(6'b011000, 32'h0,        6'b100000);
    vecs[11] = mk(6'b011010, 32'h0,        6'b110000); // inst accepted
    vecs[12] = mk(6'b001010, 32'h0,        6'b101001); // data granted next cycle
    vecs[13] = mk(6'b010010, 32'h0,        6'b000000); // FIFO full: no issue
    vecs[14] = mk(6'b010011, 32'h33333333, 6'b110100); // pop+push when full
    vecs[15] = mk(6'b010010, 32'h0,        6'b000000); // still full
    vecs[16] = mk(6'b100010, 32'h0,        6'b000001); // mid-operation reset
    vecs[17] = mk(6'b000011, 32'h44444444, 6'b000001); // stale responses dropped
    vecs[18] = mk(6'b000011, 32'h55555555, 6'b000001);
    vecs[19] = mk(6'b010010, 32'h0,        6'b110000); // count restarted at 0
    vecs[20] = mk(6'b010010, 32'h0,        6'b110000);
    vecs[21] = mk(6'b010010, 32'h0,        6'b000000); // full after exactly two
    vecs[22] = mk(6'b000011, 32'h66666666, 6'b000101);
    vecs[23] = mk(6'b000011, 32'h77777777, 6'b000101);
    vecs[24] = mk(6'b000011, 32'h88888888, 6'b000001); // empty: ignored

    reset = 1'b1; inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    inst_addr = IA; inst_size = 2'd1; data_addr = DA; data_size = 2'd2;
    data_wstrb = 4'hF; data_wdata = WD; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 25; i++) begin
      vec_t v;
      @(posedge clk); #1;
      reset = vecs[i].rst; inst_req = vecs[i].ireq; data_req = vecs[i].dreq;
      data_wr = vecs[i].dwr; mem_addr_ok = vecs[i].aok; mem_data_ok = vecs[i].dok;
      mem_rdata = vecs[i].rdata;
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      v = exp_q.pop_front();
      check($sformatf("v%0d_mem_req", i),      mem_req,      v.e_req);
      check($sformatf("v%0d_inst_addr_ok", i), inst_addr_ok, v.e_iao);
      check($sformatf("v%0d_data_addr_ok", i), data_addr_ok, v.e_dao);
      check($sformatf("v%0d_inst_data_ok", i), inst_data_ok, v.e_ido);
      check($sformatf("v%0d_data_data_ok", i), data_data_ok, v.e_ddo);
      check($sformatf("v%0d_mem_addr", i),     mem_addr,     v.e_sel ? DA : IA);
      check($sformatf("v%0d_mem_size", i),     mem_size,     v.e_sel ? 2'd2 : 2'd1);
      check($sformatf("v%0d_mem_wr", i),       mem_wr,       v.e_sel ? v.dwr : 1'b0);
      check($sformatf("v%0d_mem_wstrb", i),    mem_wstrb,    v.e_sel ? 4'hF : 4'h0);
      if (v.e_sel) check($sformatf("v%0d_mem_wdata", i), mem_wdata, WD);
      check($sformatf("v%0d_inst_rdata", i),   inst_rdata,   v.rdata);
      check($sformatf("v%0d_data_rdata", i),   data_rdata,   v.rdata);
    end

    // Alternating masters, random response delays; owners tracked in issue order.
    issued = 0;
    for (int cyc = 0; cyc < 300 && !(issued == 8 && pend_q.size() == 0); cyc++) begin
      logic dok, exp_acc, owner;
      logic [31:0] rd;
      @(posedge clk); #1;
      dok = (pend_q.size() > 0) && ($urandom_range(0, 2) == 0);
      rd  = $urandom;
      reset = 1'b0;
      inst_req = (issued < 8) && (issued % 2 == 0);
      data_req = (issued < 8) && (issued % 2 == 1);
      data_wr  = ((issued / 2) % 2) == 1;
      mem_addr_ok = 1'b1; mem_data_ok = dok; mem_rdata = rd;
      exp_acc = (issued < 8) && ((pend_q.size() < 2) || dok);
      @(negedge clk);
      if (dok) begin
        owner = pend_q.pop_front();
        check("rand_inst_data_ok", inst_data_ok, owner == 1'b0);
        check("rand_data_data_ok", data_data_ok, owner == 1'b1);
        check("rand_rdata", (owner ? data_rdata : inst_rdata), rd);
      end else begin
        check("rand_no_spurious_rsp", {inst_data_ok, data_data_ok}, 2'b00);
      end
      if (issued < 8) begin
        check($sformatf("rand_accept_%0d", issued),
              (issued % 2 == 1) ? data_addr_ok : inst_addr_ok, exp_acc);
        if (exp_acc) begin
          pend_q.push_back(issued % 2 == 1);
          issued++;
        end
      end
    end
    check("rand_all_responses_returned", (issued == 8 && pend_q.size() == 0), 1'b1);

    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
